// File: rtl/elevator_pkg.sv
// Shared types and constants for the 4-floor elevator controller slice.
package elevator_pkg;
  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10,
    S_DOOR = 2'b11
  } state_t;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_UP   = 2'b01;
  localparam logic [1:0] MOT_DOWN = 2'b10;

  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
    floor_onehot    = '0;
    floor_onehot[f] = 1'b1;
  endfunction
endpackage

// File: rtl/elevator_scheduler_if.sv
// Scheduler <-> latch/sensor/motor bundle; master drives calls and sensor, slave is the scheduler.
interface elevator_scheduler_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] req;
  logic [FLOOR_W-1:0]    floor;
  logic                  at_floor;
  logic [1:0]            motor;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] clear;
  logic [1:0]            state;
  logic                  dir;

  modport master (output req, floor, at_floor, input motor, door_open, clear, state, dir);
  modport slave  (input req, floor, at_floor, output motor, door_open, clear, state, dir);
endinterface

// File: rtl/elevator_req_scan.sv
// Combinational call scan: pending calls above, below and at the given floor.
module elevator_req_scan
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] req,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  here
);
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (i > 32'(floor)) above = above | req[i];
      if (i < 32'(floor)) below = below | req[i];
    end
    here = req[floor];
  end
endmodule

// File: rtl/elevator_scheduler.sv
// SCAN scheduler and motion/door sequencer for the 4-floor car.
// Define ELEV_SCHED_REOPEN_EN to let a new call at the open floor restart the dwell.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 8
) (
  input logic                 clk,
  input logic                 reset,
  elevator_scheduler_if.slave sched
);
  localparam int unsigned CW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]      DWELL_LOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  state_t                state_q, state_d;
  logic [1:0]            motor_q, motor_d;
  logic                  door_q, door_d;
  logic [NUM_FLOORS-1:0] clear_q, clear_d;
  logic                  dir_q, dir_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  above, below, here;
  logic                  decide, open_door;

  elevator_req_scan u_scan (
    .req   (sched.req),
    .floor (sched.floor),
    .above (above),
    .below (below),
    .here  (here)
  );

`ifdef ELEV_SCHED_REOPEN_EN
  logic [NUM_FLOORS-1:0] req_q;
  logic                  reopen;

  always_ff @(posedge clk) req_q <= sched.req;
  assign reopen = sched.req[sched.floor] & ~req_q[sched.floor];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      motor_q <= MOT_STOP;
      door_q  <= 1'b0;
      clear_q <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      motor_q <= motor_d;
      door_q  <= door_d;
      clear_q <= clear_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // IDLE and end-of-dwell share one departure decision; door entry is shared by all stops.
  always_comb begin
    state_d   = state_q;
    motor_d   = motor_q;
    door_d    = door_q;
    clear_d   = '0;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    decide    = 1'b0;
    open_door = 1'b0;

    case (state_q)
      S_IDLE: decide = 1'b1;
      S_UP: begin
        motor_d = MOT_UP;
        if (sched.at_floor && (here || sched.floor == TOP_FLOOR || !above)) open_door = 1'b1;
      end
      S_DOWN: begin
        motor_d = MOT_DOWN;
        if (sched.at_floor && (here || sched.floor == '0 || !below)) open_door = 1'b1;
      end
      S_DOOR: begin
`ifdef ELEV_SCHED_REOPEN_EN
        if (reopen) begin
          cnt_d   = DWELL_LOAD;
          clear_d = floor_onehot(sched.floor);
        end else
`endif
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             decide = 1'b1;
      end
      default: ;
    endcase

    if (decide) begin
      state_d = S_IDLE;
      motor_d = MOT_STOP;
      door_d  = 1'b0;
      if (here && sched.at_floor) begin
        open_door = 1'b1;
      end else if (above && (dir_q || !below)) begin
        state_d = S_UP;
        motor_d = MOT_UP;
        dir_d   = 1'b1;
      end else if (below) begin
        state_d = S_DOWN;
        motor_d = MOT_DOWN;
        dir_d   = 1'b0;
      end
    end

    if (open_door) begin
      state_d = S_DOOR;
      motor_d = MOT_STOP;
      door_d  = 1'b1;
      clear_d = here ? floor_onehot(sched.floor) : '0;
      cnt_d   = DWELL_LOAD;
    end
  end

  assign sched.state     = state_q;
  assign sched.motor     = motor_q;
  assign sched.door_open = door_q;
  assign sched.clear     = clear_q;
  assign sched.dir       = dir_q;
endmodule

// File: tb/tb_elevator_scheduler.sv
// Closed-loop bench: car/latch environment, directed scenarios, then random calls and resets.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  localparam int unsigned DOOR_CYCLES = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  elevator_scheduler_if bus ();

  elevator_scheduler #(.DOOR_CYCLES(DOOR_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] latch;
  int         pos;

  int         m_state;
  bit         m_dir;
  int         m_left;
  logic [1:0] m_motor;
  bit         m_door;
  logic [3:0] m_clear;
  logic [3:0] m_prev;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit calls_above(input logic [3:0] r, input int f);
    for (int i = f + 1; i < 4; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit calls_below(input logic [3:0] r, input int f);
    for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_open(input logic [3:0] r, input int f);
    m_state = 3;
    m_motor = 2'b00;
    m_door  = 1'b1;
    m_clear = r[f] ? 4'(1 << f) : 4'b0000;
    m_left  = DOOR_CYCLES;
  endtask

  task automatic model_decide(input logic [3:0] r, input int f, input bit af);
    bit up, dn;
    up = calls_above(r, f);
    dn = calls_below(r, f);
    m_door = 1'b0;
    if (r[f] && af)             model_open(r, f);
    else if (up && (m_dir || !dn)) begin m_state = 1; m_motor = 2'b01; m_dir = 1'b1; end
    else if (dn)                begin m_state = 2; m_motor = 2'b10; m_dir = 1'b0; end
    else                        begin m_state = 0; m_motor = 2'b00; end
  endtask

  task automatic model_step(input bit rst, input logic [3:0] r, input int f, input bit af);
    logic [3:0] prev;
    prev   = m_prev;
    m_prev = r;
    if (rst) begin
      m_state = 0; m_motor = 2'b00; m_door = 1'b0; m_clear = 4'b0000; m_dir = 1'b1; m_left = 0;
      return;
    end
    m_clear = 4'b0000;
    case (m_state)
      0: model_decide(r, f, af);
      1: if (af && (r[f] || f == 3 || !calls_above(r, f))) model_open(r, f);
      2: if (af && (r[f] || f == 0 || !calls_below(r, f))) model_open(r, f);
      default: begin
`ifdef ELEV_SCHED_REOPEN_EN
        if (r[f] && !prev[f]) begin
          m_left  = DOOR_CYCLES;
          m_clear = 4'(1 << f);
        end else
`endif
        begin
          m_left--;
          if (m_left == 0) model_decide(r, f, af);
        end
      end
    endcase
  endtask

  task automatic compare_model();
    check("state",     {6'b0, bus.state},     8'(m_state));
    check("motor",     {6'b0, bus.motor},     {6'b0, m_motor});
    check("door_open", {7'b0, bus.door_open}, {7'b0, m_door});
    check("clear",     {4'b0, bus.clear},     {4'b0, m_clear});
    check("dir",       {7'b0, bus.dir},       {7'b0, m_dir});
  endtask

  // Latch clears on the DUT pulse, car moves one step per cycle, three steps per floor.
  task automatic cycle(input bit rst, input logic [3:0] calls);
    @(negedge clk);
    latch = (latch & ~bus.clear) | calls;
    if (bus.motor == MOT_UP && pos < 9)        pos++;
    else if (bus.motor == MOT_DOWN && pos > 0) pos--;
    reset        = rst;
    bus.req      = latch;
    bus.floor    = 2'(pos / 3);
    bus.at_floor = (pos % 3 == 0);
    @(posedge clk);
    model_step(rst, latch, pos / 3, pos % 3 == 0);
    #1 compare_model();
  endtask

  task automatic run_until_door(input string tag);
    int n = 0;
    while (bus.door_open !== 1'b1 && n < 60) begin
      cycle(1'b0, 4'b0000);
      n++;
    end
    check({tag, "_reached"}, {7'b0, bus.door_open}, 8'd1);
  endtask

  task automatic measure_dwell(input int inject_at, input logic [3:0] bits,
                               output int len, output int pulses);
    len    = 0;
    pulses = 0;
    while (bus.door_open === 1'b1 && len < 64) begin
      len++;
      if (bus.clear !== 4'b0000) pulses++;
      cycle(1'b0, (len == inject_at) ? bits : 4'b0000);
    end
  endtask

  initial begin
    int len, pulses, n;
    latch = 4'b0100; pos = 0; reset = 1'b1;
    bus.req = latch; bus.floor = 2'd0; bus.at_floor = 1'b1;
    m_state = 0; m_motor = 2'b00; m_door = 1'b0; m_clear = 4'b0000;
    m_dir = 1'b1; m_left = 0; m_prev = latch;

    // Reset values, then departure upward one cycle after release
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    check("rst_state", {6'b0, bus.state}, 8'd0);
    check("rst_motor", {6'b0, bus.motor}, 8'd0);
    check("rst_door",  {7'b0, bus.door_open}, 8'd0);
    check("rst_clear", {4'b0, bus.clear}, 8'd0);
    check("rst_dir",   {7'b0, bus.dir}, 8'd1);
    cycle(1'b0, 4'b0000);
    check("depart_state", {6'b0, bus.state}, 8'd1);
    check("depart_motor", {6'b0, bus.motor}, 8'd1);
    check("depart_dir",   {7'b0, bus.dir}, 8'd1);

    // Pass floor 1 without a call, stop and dwell at 2
    run_until_door("serve2");
    check("serve2_floor", {6'b0, bus.floor}, 8'd2);
    check("serve2_state", {6'b0, bus.state}, 8'd3);
    check("serve2_motor", {6'b0, bus.motor}, 8'd0);
    check("serve2_clear", {4'b0, bus.clear}, 8'b0100);
    measure_dwell(0, 4'b0000, len, pulses);
    check("serve2_dwell",  8'(len), 8'(DOOR_CYCLES));
    check("serve2_pulses", 8'(pulses), 8'd1);
    check("serve2_after",  {6'b0, bus.state}, 8'd0);

    // Reset while travelling down
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b0000);
    cycle(1'b0, 4'b0000);
    check("down_motor", {6'b0, bus.motor}, 8'd2);
    cycle(1'b1, 4'b0000);
    check("midrst_motor", {6'b0, bus.motor}, 8'd0);
    check("midrst_state", {6'b0, bus.state}, 8'd0);
    check("midrst_dir",   {7'b0, bus.dir}, 8'd1);
    check("midrst_door",  {7'b0, bus.door_open}, 8'd0);
    run_until_door("serve0");
    check("serve0_clear", {4'b0, bus.clear}, 8'b0001);
    measure_dwell(0, 4'b0000, len, pulses);

    // From floor 1 with calls at 3 and 0: up first, then reverse
    cycle(1'b0, 4'b0010);
    run_until_door("serve1");
    measure_dwell(0, 4'b0000, len, pulses);
    cycle(1'b0, 4'b1001);
    check("scan_up_state", {6'b0, bus.state}, 8'd1);
    run_until_door("serve3");
    check("serve3_clear", {4'b0, bus.clear}, 8'b1000);
    measure_dwell(0, 4'b0000, len, pulses);
    check("reverse_state", {6'b0, bus.state}, 8'd2);
    check("reverse_dir",   {7'b0, bus.dir}, 8'd0);
    run_until_door("serve0b");
    check("serve0b_clear", {4'b0, bus.clear}, 8'b0001);
    measure_dwell(0, 4'b0000, len, pulses);

    // Call at floor 1 appears exactly as the car arrives there going up
    cycle(1'b0, 4'b1000);
    n = 0;
    while (pos != 2 && n < 30) begin cycle(1'b0, 4'b0000); n++; end
    cycle(1'b0, 4'b0010);
    check("late_state", {6'b0, bus.state}, 8'd3);
    check("late_clear", {4'b0, bus.clear}, 8'b0010);
    measure_dwell(0, 4'b0000, len, pulses);
    run_until_door("serve3b");
    measure_dwell(0, 4'b0000, len, pulses);

    // New call at the open floor on dwell cycle 5
    cycle(1'b0, 4'b0100);
    run_until_door("serve2b");
    check("serve2b_clear", {4'b0, bus.clear}, 8'b0100);
    measure_dwell(5, 4'b0100, len, pulses);
`ifdef ELEV_SCHED_REOPEN_EN
    check("recall_dwell", 8'(len), 8'(5 + DOOR_CYCLES));
`else
    check("recall_dwell", 8'(len), 8'(2 * DOOR_CYCLES));
`endif
    check("recall_pulses", 8'(pulses), 8'd2);
    check("recall_after",  {6'b0, bus.state}, 8'd0);

    // Random calls with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] calls;
      calls = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      cycle($urandom_range(0, 399) == 0, calls);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the 4-floor elevator. It consumes the latched call vector from the per-floor button latch and the floor sensor, and selects travel direction with a collective (SCAN) policy. It drives the motor command and times door dwell. It also issues one-cycle clear pulses back to the button latch for each serviced floor.

## Interface
- DOOR_CYCLES, 8, door-open dwell in clock cycles (≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  4  latched pending calls, bit i = floor i
- floor  in  2  current/last-passed floor from sensor
- at_floor  in  1  car aligned with `floor` (stopping allowed)
- motor  out  2  00 stop, 01 up, 10 down (11 never driven)
- door_open  out  1  door command
- clear  out  4  one-hot, one-cycle pulse: clear req bit of serviced floor
- state  out  2  00 IDLE, 01 UP, 10 DOWN, 11 DOOR
- dir  out  1  last travel direction, 1 = up

## Operation
- Reset: state IDLE, motor 00, door_open 0, clear 0000, dir 1, door counter 0.
- above = |req bits > floor; below = |req bits < floor; here = req[floor].
- IDLE:
  - here & at_floor → DOOR.
  - else above & (dir | !below) → UP, dir=1.
  - else below → DOWN, dir=0.
  - else stay.
- UP: motor 01.
  - at_floor & (here | floor==3 | !above) → DOOR, motor 00.
  - Passing a floor without a call does not stop.
- DOWN: mirror of UP. Motor 10; stops on here, floor==0, or !below.
- DOOR:
  - Entry cycle: clear = onehot(floor) for one cycle only if req[floor]=1, else 0000. door_open=1 and counter loads DOOR_CYCLES-1.
  - Counter decrements to 0. Then door_open=0 and next state is chosen as in IDLE, with current dir preferred, i.e. continue if calls remain ahead, else reverse.
- Motor is never nonzero while door_open=1.
- Request bits set during travel toward the car's direction are picked up on the next at_floor.
- Calls behind the car wait for reversal.
- Reset mid-move or mid-dwell: next cycle all outputs at reset values. Pending req bits are untouched (owned by the latch).

## Timing
- All outputs registered. State, motor, door_open and clear change on the same edge.
- Decision latency: 1 cycle from req/at_floor sample to motor/state update.
- DOOR dwell: door_open high for exactly DOOR_CYCLES cycles. The first cycle after dwell shows the new state/motor.
- clear is high exactly one cycle, coincident with the first door_open cycle.
- Simultaneous above & below in IDLE: dir wins.
- here & above on the same cycle: here wins (door first).

## Configuration
- ELEV_SCHED_REOPEN_EN defined: a new req[floor] rising while in DOOR reloads the counter to DOOR_CYCLES-1 and pulses clear for that floor.
- Undefined: a call at the current floor during dwell is ignored until the next departure decision. It is then served by an immediate re-entry to DOOR.

## Structure
- Shared package elevator_pkg:
  - state encoding localparams (S_IDLE, S_UP, S_DOWN, S_DOOR)
  - motor codes (MOT_STOP, MOT_UP, MOT_DOWN)
  - NUM_FLOORS=4
- Sub-module elevator_req_scan: combinational above/below/here from req and floor. It is reused by the display logic.
- Door counter stays inline.

## Test plan
- Reset with req=0100, floor=0: all outputs at reset values. Release reset → 1 cycle later state=UP, motor=01, dir=1.
- From floor 0 going up, at_floor with floor=1, 2, req=0100:
  - No stop at 1.
  - At floor 2: motor=00, state=DOOR, clear=0100 for 1 cycle, door_open high 8 cycles, then IDLE.
- Car at floor 1 idle, dir=1, req=1001: goes UP. Serves 3, then reverses DOWN and serves 0. Clear pulses 1000 then 0001.
- Car moving UP past floor 1 when req[1] sets while at_floor, floor=1: stops at 1. Clear=0010.
- Reset asserted during DOWN with motor=10: next cycle motor=00, state=IDLE, dir=1, door_open=0.
- ELEV_SCHED_REOPEN_EN: in DOOR at floor 2, req[2] rises on cycle 5 of dwell → door_open extends to 5+8 total cycles and a second clear=0100 pulse occurs. Without the macro: dwell stays 8 cycles, then immediate re-entry to DOOR.
